// File: rtl/p251_pkg.sv
// Shared GF(251) constants, FSM state encoding and the canonical modular adder.
// Used by p251_add and p251_acc.
package p251_pkg;

    localparam int P251_Q = 251;
    localparam int P251_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_ACC  = ACC,
        S_DONE = DONE
    } state_t;

    function automatic logic [P251_W-1:0] p251_add_f(
        input logic [P251_W-1:0] a,
        input logic [P251_W-1:0] b
    );
        logic [P251_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 9'(P251_Q))
            s = s - 9'(P251_Q);
        return s[P251_W-1:0];
    endfunction

endpackage

// File: rtl/p251_add.sv
// Combinational canonical adder: y = (a + b) mod 251 for canonical inputs.
// Shared by the accumulator and other GF(251) datapath blocks.
module p251_add
    import p251_pkg::*;
(
    input  logic [P251_W-1:0] a,
    input  logic [P251_W-1:0] b,
    output logic [P251_W-1:0] y
);

    assign y = p251_add_f(a, b);

endmodule

// File: rtl/p251_acc.sv
// GF(251) inner-product accumulator: sums N_TERMS products mod 251 per run.
// Optional P251_ACC_RANGE_CHECK_EN adds a sticky err flag for inputs >= 251.
module p251_acc
    import p251_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int WIDTH   = 8,
    parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy
`ifdef P251_ACC_RANGE_CHECK_EN
   ,output logic             err
`endif
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] cnt_base;
    logic             accept;
    logic             last;

    // A start restarts the run, so its coincident term adds onto zero.
    assign accept = in_valid && (start || state == S_ACC);
    assign base   = start ? '0 : acc;

    p251_add u_add (
        .a (base),
        .b (in_data),
        .y (sum)
    );

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        count_n  = count;
        last     = 1'b0;
        cnt_base = start ? '0 : count;
        if (accept) begin
            acc_n   = sum;
            count_n = cnt_base + CNT_W'(1);
            last    = (count_n == CNT_W'(N_TERMS));
        end else if (start) begin
            acc_n   = '0;
            count_n = '0;
        end
        if (last)
            state_n = S_DONE;
        else if (start)
            state_n = S_ACC;
        else if (state == S_DONE)
            state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            count <= '0;
            out   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            count <= count_n;
            if (last)
                out <= acc_n;
        end
    end

    assign done = (state == S_DONE);
    assign busy = (state == S_ACC);

`ifdef P251_ACC_RANGE_CHECK_EN
    logic bad;

    assign bad = accept && (in_data >= WIDTH'(P251_Q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (start)
            err <= bad;
        else
            err <= err | bad;
    end
`endif

endmodule

// File: tb/tb_p251_acc.sv
// Scoreboard bench for p251_acc: main instance N_TERMS=3, side instance N_TERMS=1.
// Define P251_ACC_RANGE_CHECK_EN to also exercise the err flag.
module tb_p251_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic [7:0] out;
    logic       done;
    logic       busy;
    logic [7:0] out1;
    logic       done1;
    logic       busy1;
`ifdef P251_ACC_RANGE_CHECK_EN
    logic       err;
    logic       err1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    p251_acc #(.N_TERMS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out      (out),
        .done     (done),
        .busy     (busy)
`ifdef P251_ACC_RANGE_CHECK_EN
       ,.err      (err)
`endif
    );

    p251_acc #(.N_TERMS(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out      (out1),
        .done     (done1),
        .busy     (busy1)
`ifdef P251_ACC_RANGE_CHECK_EN
       ,.err      (err1)
`endif
    );

    function automatic int mod_sum(input int a, input int b, input int c);
        return (a + b + c) % 251;
    endfunction

    // Inputs change at a falling edge; outputs are read at the next one.
    task automatic step(input logic st, input logic vl, input logic [7:0] d);
        start    = st;
        in_valid = vl;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out !== 8'd0 || done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: out=%0d done=%b busy=%b, need 0/0/0",
                     out, done, busy);
        end
`ifdef P251_ACC_RANGE_CHECK_EN
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err: err=%b, need 0", err);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic feed(input string name,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input int g1, input int g2);
        int e;
        step(1'b1, 1'b0, 8'd0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_busy: busy=%b, need 1", name, busy);
        end
        step(1'b0, 1'b1, a);
        repeat (g1) step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, b);
        repeat (g2) step(1'b0, 1'b0, 8'd0);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_early: done=%b before last term, need 0",
                     name, done);
        end
        exp_q.push_back(mod_sum(a, b, c));
        step(1'b0, 1'b1, c);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_latency: done=%b busy=%b, need 1/0",
                     name, done, busy);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp++;
        if (int'(out) !== e) begin
            n_bad++;
            $display("FAIL %s_out: out=%0d, need %0d", name, out, e);
        end
        step(1'b0, 1'b0, 8'd0);
        n_cmp++;
        if (done !== 1'b0 || int'(out) !== e) begin
            n_bad++;
            $display("FAIL %s_width: done=%b out=%0d, need 0/%0d",
                     name, done, out, e);
        end
    endtask

    task automatic test_mul_stream;
        feed("mul", 8'd20, 8'd50, 8'd250, 0, 0);
    endtask

    task automatic test_wrap;
        feed("wrap_hi", 8'd250, 8'd250, 8'd0, 0, 0);
        feed("wrap_zero", 8'd0, 8'd0, 8'd0, 0, 0);
    endtask

    task automatic test_gapped;
        feed("gap", 8'd100, 8'd100, 8'd100, 3, 1);
    endtask

    task automatic test_restart;
        int e;
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd10);
        step(1'b0, 1'b1, 8'd20);
        step(1'b1, 1'b1, 8'd5);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_abort: done=%b busy=%b, need 0/1",
                     done, busy);
        end
        step(1'b0, 1'b1, 8'd6);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_early: done=%b, need 0", done);
        end
        exp_q.push_back(mod_sum(5, 6, 7));
        step(1'b0, 1'b1, 8'd7);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp++;
        if (done !== 1'b1 || int'(out) !== e) begin
            n_bad++;
            $display("FAIL restart_out: done=%b out=%0d, need 1/%0d",
                     done, out, e);
        end
        step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_reset_mid;
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd40);
        step(1'b0, 1'b1, 8'd40);
        start = 1'b0;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out !== 8'd0 || done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: out=%0d done=%b busy=%b, need 0/0/0",
                     out, done, busy);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 8'd0);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_nodone: done=%b, need 0", done);
        end
        feed("fresh", 8'd1, 8'd2, 8'd3, 0, 0);
    endtask

    task automatic test_back_to_back;
        int e;
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd1);
        step(1'b0, 1'b1, 8'd2);
        exp_q.push_back(mod_sum(1, 2, 3));
        step(1'b0, 1'b1, 8'd3);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp++;
        if (done !== 1'b1 || int'(out) !== e) begin
            n_bad++;
            $display("FAIL b2b_first: done=%b out=%0d, need 1/%0d",
                     done, out, e);
        end
        step(1'b1, 1'b0, 8'd0);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || int'(out) !== e) begin
            n_bad++;
            $display("FAIL b2b_restart: busy=%b done=%b out=%0d, need 1/0/%0d",
                     busy, done, out, e);
        end
        step(1'b0, 1'b1, 8'd4);
        step(1'b0, 1'b1, 8'd5);
        exp_q.push_back(mod_sum(4, 5, 6));
        step(1'b0, 1'b1, 8'd6);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp++;
        if (done !== 1'b1 || int'(out) !== e) begin
            n_bad++;
            $display("FAIL b2b_second: done=%b out=%0d, need 1/%0d",
                     done, out, e);
        end
        step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_single_term;
        step(1'b1, 1'b1, 8'd77);
        n_cmp++;
        if (done1 !== 1'b1 || out1 !== 8'd77) begin
            n_bad++;
            $display("FAIL n1_first: done=%b out=%0d, need 1/77", done1, out1);
        end
        step(1'b1, 1'b1, 8'd5);
        n_cmp++;
        if (done1 !== 1'b1 || out1 !== 8'd5) begin
            n_bad++;
            $display("FAIL n1_second: done=%b out=%0d, need 1/5", done1, out1);
        end
        step(1'b0, 1'b0, 8'd0);
        n_cmp++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || out1 !== 8'd5) begin
            n_bad++;
            $display("FAIL n1_idle: done=%b busy=%b out=%0d, need 0/0/5",
                     done1, busy1, out1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef P251_ACC_RANGE_CHECK_EN
    task automatic test_range_check;
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd251);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: err=%b, need 1", err);
        end
        step(1'b0, 1'b1, 8'd3);
        step(1'b0, 1'b1, 8'd1);
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_done: done=%b err=%b, need 1/1", done, err);
        end
        step(1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: err=%b, need 0", err);
        end
        step(1'b0, 1'b1, 8'd1);
        step(1'b0, 1'b1, 8'd1);
        step(1'b0, 1'b1, 8'd1);
        n_cmp++;
        if (done !== 1'b1 || out !== 8'd3 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clean: done=%b out=%0d err=%b, need 1/3/0",
                     done, out, err);
        end
        step(1'b0, 1'b0, 8'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_mul_stream();
        test_wrap();
        test_gapped();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        test_single_term();
`ifdef P251_ACC_RANGE_CHECK_EN
        test_range_check();
`endif
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
